// File: rtl/vape_pkg.sv
// Shared definitions for the VAPE DMA arbiter and the output-protection monitor.
// Holds the arbiter state encoding, address width and the inclusive range test.
package vape_pkg;

  localparam int ADDR_W  = 16;
  localparam int STALL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } vape_state_e;

  // Inclusive bounds on both ends, matching how ER/OR limits are programmed.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/vape_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
// Rotates the request vector down by ptr, takes the lowest set bit, rotates back up.
module vape_rr_pick
  import vape_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] rot;
  logic [2*N_REQ-1:0] pick_dbl;
  logic [N_REQ-1:0]   first;

  always_comb begin
    req_dbl = {req, req};
    rot     = req_dbl >> ptr;
    first   = '0;
    valid   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && rot[k]) begin
        first[k] = 1'b1;
        valid    = 1'b1;
      end
    end
    pick_dbl = {{N_REQ{1'b0}}, first} << ptr;
    pick     = pick_dbl[N_REQ-1:0] | pick_dbl[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/vape_dma_arbiter.sv
// Round-robin DMA port arbiter that defers output-region writes during attested execution.
// A deferred beat is forced through after STALL_MAX hold cycles and flagged on stall_ovf.
module vape_dma_arbiter
  import vape_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int BURST_MAX = 8,
  parameter int STALL_MAX = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_wr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    dma_en,
  output logic [ADDR_W-1:0]       dma_addr,
  output logic                    dma_wr,
  input  logic [ADDR_W-1:0]       pc,
  input  logic [ADDR_W-1:0]       ER_min,
  input  logic [ADDR_W-1:0]       ER_max,
  input  logic [ADDR_W-1:0]       OR_min,
  input  logic [ADDR_W-1:0]       OR_max,
  input  logic                    exec_in,
  output logic                    hold,
  output logic                    stall_ovf,
  output vape_state_e             fsm_state
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_REQ - 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  localparam logic [BEAT_W-1:0]  BEAT_FULL = BEAT_W'(BURST_MAX);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  vape_state_e        state, state_n;
  logic [N_REQ-1:0]   gnt_n;
  logic [IDX_W-1:0]   rr_ptr, rr_n, rr_next;
  logic [BEAT_W-1:0]  beat_cnt, beat_n;
  logic [STALL_W-1:0] stall_cnt, stall_n;
  logic               en_n, wr_n, ovf_n;
  logic [ADDR_W-1:0]  addr_n;

  logic [N_REQ-1:0]   pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   g_idx;
  logic [ADDR_W-1:0]  g_addr;
  logic               g_req, g_wr;
  logic               or_hit, in_er, defer_now;
  logic               owned, force_beat, accept, do_release;

  vape_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    g_idx  = '0;
    g_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        g_idx  = IDX_W'(i);
        g_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign g_req      = |(gnt & req);
  assign g_wr       = |(gnt & req_wr);
  assign or_hit     = g_wr && in_range(g_addr, OR_min, OR_max);
  assign in_er      = in_range(pc, ER_min, ER_max);
  assign defer_now  = or_hit && exec_in && !in_er;
  assign owned      = (state != ST_IDLE);
  assign force_beat = (state == ST_HOLD) && (stall_cnt == STALL_LIM);
  assign rr_next    = (g_idx == IDX_LAST) ? '0 : g_idx + IDX_W'(1);

  // Handshake: a requester holds req (with addr/wr stable) until its beat is accepted;
  // a beat is accepted on the cycle gnt[i] && req[i] && !hold, and appears on dma_* one cycle later.
  assign accept    = owned && g_req && (!defer_now || force_beat);
  assign hold      = owned && g_req && defer_now && !force_beat;
  assign fsm_state = state;

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    rr_n       = rr_ptr;
    beat_n     = beat_cnt;
    stall_n    = stall_cnt;
    en_n       = 1'b0;
    addr_n     = dma_addr;
    wr_n       = dma_wr;
    ovf_n      = 1'b0;
    do_release = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_n = ST_GRANT;
          gnt_n   = pick;
          beat_n  = '0;
          stall_n = '0;
        end
      end
      ST_GRANT, ST_HOLD: begin
        if (!g_req) begin
          do_release = 1'b1;
        end else if (accept) begin
          en_n    = 1'b1;
          addr_n  = g_addr;
          wr_n    = g_wr;
          // Accepting while still deferred is only possible through the stall limit.
          ovf_n   = defer_now;
          stall_n = '0;
          beat_n  = (beat_cnt == BEAT_FULL) ? beat_cnt : beat_cnt + BEAT_W'(1);
          if (beat_cnt == BEAT_LAST) begin
            do_release = 1'b1;
          end else begin
            state_n = ST_GRANT;
          end
        end else begin
          state_n = ST_HOLD;
          stall_n = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + STALL_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
    // Release always passes through IDLE so the next owner waits one cycle.
    if (do_release) begin
      state_n = ST_IDLE;
      gnt_n   = '0;
      rr_n    = rr_next;
      beat_n  = '0;
      stall_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      dma_en    <= 1'b0;
      dma_addr  <= '0;
      dma_wr    <= 1'b0;
      stall_ovf <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      rr_ptr    <= rr_n;
      beat_cnt  <= beat_n;
      stall_cnt <= stall_n;
      dma_en    <= en_n;
      dma_addr  <= addr_n;
      dma_wr    <= wr_n;
      stall_ovf <= ovf_n;
    end
  end

endmodule

// File: tb/tb_vape_dma_arbiter.sv
// Directed bench for vape_dma_arbiter: round-robin bursts, OR write deferral,
// stall overflow, non-OR traffic, reset mid-operation and range boundaries.
module tb_vape_dma_arbiter;
  import vape_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] req_addr;
  logic [1:0]  req_wr;
  logic [1:0]  gnt;
  logic        dma_en;
  logic [15:0] dma_addr;
  logic        dma_wr;
  logic [15:0] pc, ER_min, ER_max, OR_min, OR_max;
  logic        exec_in;
  logic        hold;
  logic        stall_ovf;
  vape_state_e fsm_state;

  int check_cnt = 0;
  int pass_cnt  = 0;

  vape_dma_arbiter #(
    .N_REQ     (2),
    .BURST_MAX (8),
    .STALL_MAX (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_wr    (req_wr),
    .gnt       (gnt),
    .dma_en    (dma_en),
    .dma_addr  (dma_addr),
    .dma_wr    (dma_wr),
    .pc        (pc),
    .ER_min    (ER_min),
    .ER_max    (ER_max),
    .OR_min    (OR_min),
    .OR_max    (OR_max),
    .exec_in   (exec_in),
    .hold      (hold),
    .stall_ovf (stall_ovf),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic go_idle();
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", gnt); else pass_cnt++;
    check_cnt++; if (dma_en !== 1'b0) $display("FAIL rst_dma_en: got %b want 0", dma_en); else pass_cnt++;
    check_cnt++; if (dma_addr !== 16'h0000) $display("FAIL rst_dma_addr: got %h want 0000", dma_addr); else pass_cnt++;
    check_cnt++; if (hold !== 1'b0) $display("FAIL rst_hold: got %b want 0", hold); else pass_cnt++;
    check_cnt++; if (stall_ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", stall_ovf); else pass_cnt++;
    check_cnt++; if (fsm_state !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", fsm_state, ST_IDLE); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic       exp_en;
    req = 2'b11; req_addr = {16'h2000, 16'h1000}; req_wr = 2'b00;
    exec_in = 1'b0; pc = 16'hE000;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_gnt = (k <= 8) ? 2'b01 : ((k == 9) ? 2'b00 : 2'b10);
      exp_en  = ((k >= 2) && (k <= 9)) || (k == 11);
      check_cnt++; if (gnt !== exp_gnt) $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); else pass_cnt++;
      check_cnt++; if (dma_en !== exp_en) $display("FAIL rr_dma_en[%0d]: got %b want %b", k, dma_en, exp_en); else pass_cnt++;
      if (k == 2) begin
        check_cnt++; if (dma_addr !== 16'h1000) $display("FAIL rr_addr0: got %h want 1000", dma_addr); else pass_cnt++;
      end
      if (k == 11) begin
        check_cnt++; if (dma_addr !== 16'h2000) $display("FAIL rr_addr1: got %h want 2000", dma_addr); else pass_cnt++;
      end
    end
    req = 2'b00;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b00) $display("FAIL rr_release: got %b want 00", gnt); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_defer();
    pc = 16'hE000; exec_in = 1'b1;
    req = 2'b01; req_addr = {16'h0000, 16'h0400}; req_wr = 2'b01;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b01) $display("FAIL def_gnt: got %b want 01", gnt); else pass_cnt++;
    check_cnt++; if (hold !== 1'b1) $display("FAIL def_hold1: got %b want 1", hold); else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++; if (hold !== 1'b1) $display("FAIL def_hold4: got %b want 1", hold); else pass_cnt++;
    check_cnt++; if (dma_en !== 1'b0) $display("FAIL def_no_en: got %b want 0", dma_en); else pass_cnt++;
    check_cnt++; if (fsm_state !== ST_HOLD) $display("FAIL def_state: got %0d want %0d", fsm_state, ST_HOLD); else pass_cnt++;
    pc = 16'hC010;
    #1;
    check_cnt++; if (hold !== 1'b0) $display("FAIL def_hold_drop: got %b want 0", hold); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (dma_en !== 1'b1) $display("FAIL def_en: got %b want 1", dma_en); else pass_cnt++;
    check_cnt++; if (dma_addr !== 16'h0400) $display("FAIL def_addr: got %h want 0400", dma_addr); else pass_cnt++;
    check_cnt++; if (dma_wr !== 1'b1) $display("FAIL def_wr: got %b want 1", dma_wr); else pass_cnt++;
    check_cnt++; if (stall_ovf !== 1'b0) $display("FAIL def_ovf: got %b want 0", stall_ovf); else pass_cnt++;
    req = 2'b00;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b00) $display("FAIL def_release: got %b want 00", gnt); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_overflow();
    int hold_cycles = 0;
    int leak = 0;
    pc = 16'hE000; exec_in = 1'b1;
    req = 2'b01; req_addr = {16'h0000, 16'h0400}; req_wr = 2'b01;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (hold !== 1'b1) break;
      hold_cycles++;
      if (dma_en !== 1'b0 || stall_ovf !== 1'b0) leak++;
    end
    check_cnt++; if (hold_cycles != 255) $display("FAIL ovf_hold_cycles: got %0d want 255", hold_cycles); else pass_cnt++;
    check_cnt++; if (leak != 0) $display("FAIL ovf_leak: got %0d want 0", leak); else pass_cnt++;
    check_cnt++; if (dma_en !== 1'b0) $display("FAIL ovf_pre_en: got %b want 0", dma_en); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (dma_en !== 1'b1) $display("FAIL ovf_en: got %b want 1", dma_en); else pass_cnt++;
    check_cnt++; if (stall_ovf !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", stall_ovf); else pass_cnt++;
    check_cnt++; if (dma_addr !== 16'h0400) $display("FAIL ovf_addr: got %h want 0400", dma_addr); else pass_cnt++;
    req = 2'b00;
    @(negedge clk);
    check_cnt++; if (stall_ovf !== 1'b0) $display("FAIL ovf_one_cycle: got %b want 0", stall_ovf); else pass_cnt++;
    check_cnt++; if (gnt !== 2'b00) $display("FAIL ovf_release: got %b want 00", gnt); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_non_or();
    pc = 16'hE000; exec_in = 1'b1;
    req = 2'b01; req_addr = {16'h0000, 16'h0600}; req_wr = 2'b01;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b01) $display("FAIL nor_gnt: got %b want 01", gnt); else pass_cnt++;
    check_cnt++; if (hold !== 1'b0) $display("FAIL nor_hold_wr: got %b want 0", hold); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (dma_en !== 1'b1 || dma_addr !== 16'h0600 || dma_wr !== 1'b1)
      $display("FAIL nor_wr_beat: got en=%b addr=%h wr=%b want en=1 addr=0600 wr=1", dma_en, dma_addr, dma_wr);
    else pass_cnt++;
    req_addr = {16'h0000, 16'h0400}; req_wr = 2'b00;
    #1;
    check_cnt++; if (hold !== 1'b0) $display("FAIL nor_hold_rd: got %b want 0", hold); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (dma_en !== 1'b1 || dma_addr !== 16'h0400 || dma_wr !== 1'b0)
      $display("FAIL nor_rd_beat: got en=%b addr=%h wr=%b want en=1 addr=0400 wr=0", dma_en, dma_addr, dma_wr);
    else pass_cnt++;
    req = 2'b00;
    go_idle();
  endtask

  task automatic test_reset_mid();
    // rr pointer is 1 here, so requester 1 (a deferred OR write) wins first.
    pc = 16'hE000; exec_in = 1'b1;
    req = 2'b11; req_addr = {16'h0400, 16'h1000}; req_wr = 2'b10;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b10 || hold !== 1'b1) $display("FAIL rm_pre_gnt: got gnt=%b hold=%b want gnt=10 hold=1", gnt, hold); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b00 || dma_en !== 1'b0 || hold !== 1'b0)
      $display("FAIL rm_hold_rst: got gnt=%b en=%b hold=%b want 00/0/0", gnt, dma_en, hold);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b01) $display("FAIL rm_first_gnt: got %b want 01", gnt); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (dma_en !== 1'b1) $display("FAIL rm_burst_en: got %b want 1", dma_en); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    check_cnt++; if (gnt !== 2'b00 || dma_en !== 1'b0)
      $display("FAIL rm_burst_rst: got gnt=%b en=%b want 00/0", gnt, dma_en);
    else pass_cnt++;
    rst = 1'b0;
    go_idle();
  endtask

  task automatic test_boundaries();
    logic [15:0] t_addr [6];
    logic [15:0] t_pc   [6];
    logic        t_hold [6];
    t_addr = '{16'h0400, 16'h04FF, 16'h0500, 16'h0400, 16'h0400, 16'h03FF};
    t_pc   = '{16'hE000, 16'hE000, 16'hE000, 16'hC0FF, 16'hC100, 16'hE000};
    t_hold = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0};
    for (int i = 0; i < 6; i++) begin
      exec_in = 1'b1; pc = t_pc[i];
      req = 2'b01; req_addr = {16'h0000, t_addr[i]}; req_wr = 2'b01;
      @(negedge clk);
      check_cnt++; if (gnt !== 2'b01 || hold !== t_hold[i])
        $display("FAIL bnd_hold[%0d]: got gnt=%b hold=%b want gnt=01 hold=%b", i, gnt, hold, t_hold[i]);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (dma_en !== !t_hold[i])
        $display("FAIL bnd_en[%0d]: got %b want %b", i, dma_en, !t_hold[i]);
      else pass_cnt++;
      req = 2'b00;
      @(negedge clk);
      check_cnt++; if (gnt !== 2'b00) $display("FAIL bnd_release[%0d]: got %b want 00", i, gnt); else pass_cnt++;
    end
    go_idle();
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; req_addr = '0; req_wr = 2'b00;
    pc = 16'hE000; exec_in = 1'b0;
    ER_min = 16'hC000; ER_max = 16'hC0FF;
    OR_min = 16'h0400; OR_max = 16'h04FF;
    test_reset();
    test_round_robin();
    test_defer();
    test_overflow();
    test_non_or();
    test_reset_mid();
    test_boundaries();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
